// File: rtl/exu_ctrl.sv
`timescale 1ns/1ps
// exu_ctrl: multi-cycle execute-stage sequencer.
//
// Accepts one decoded instruction at a time from the IDU (in_valid/in_ready) and
// time-multiplexes the shared ALU over one or two phases. It drives the LSU store
// request, pulses the register-file/PC write enables at writeback, and halts on
// ebreak, an illegal instruction number, or a store timeout.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   instruction handshake; inst_num sampled on accept
//   alu_result          shared ALU output (beq tests it for zero)
//   alu_phase           ALU operation select (0 = first, 1 = second)
//   link_wen/target_wen latch alu_result as link value / next-PC target
//   mem_req/mem_ready   store request and completion
//   reg_wen/pc_wen      writeback pulses; pc_sel picks target (1) or pc+4 (0)
//   halt/err            sticky halt and error
//   retired             retired-instruction counter (wraps)

`ifndef INST_NUM_WIDTH
`define INST_NUM_WIDTH 6
`endif
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef INST_ADD
`define INST_ADD 1
`endif
`ifndef INST_ADDI
`define INST_ADDI 2
`endif
`ifndef INST_AUIPC
`define INST_AUIPC 3
`endif
`ifndef INST_JAL
`define INST_JAL 4
`endif
`ifndef INST_JALR
`define INST_JALR 5
`endif
`ifndef INST_BEQ
`define INST_BEQ 6
`endif
`ifndef INST_SW
`define INST_SW 7
`endif
`ifndef INST_EBREAK
`define INST_EBREAK 8
`endif

module exu_ctrl #(
  parameter int unsigned INST_NUM_WIDTH = `INST_NUM_WIDTH,
  parameter int unsigned ISA_WIDTH      = `ISA_WIDTH,
  parameter int unsigned MEM_TIMEOUT    = 255,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INST_NUM_WIDTH-1:0] inst_num,
  input  logic [ISA_WIDTH-1:0]      alu_result,
  output logic                      alu_phase,
  output logic                      link_wen,
  output logic                      target_wen,
  output logic                      mem_req,
  input  logic                      mem_ready,
  output logic                      reg_wen,
  output logic                      pc_wen,
  output logic                      pc_sel,
  output logic                      halt,
  output logic                      err,
  output logic [CNT_WIDTH-1:0]      retired
);

  // Wait counter only needs to reach MEM_TIMEOUT before the controller leaves MEM.
  localparam int unsigned WaitW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  localparam logic [INST_NUM_WIDTH-1:0] InstAdd    = INST_NUM_WIDTH'(`INST_ADD);
  localparam logic [INST_NUM_WIDTH-1:0] InstAddi   = INST_NUM_WIDTH'(`INST_ADDI);
  localparam logic [INST_NUM_WIDTH-1:0] InstAuipc  = INST_NUM_WIDTH'(`INST_AUIPC);
  localparam logic [INST_NUM_WIDTH-1:0] InstJal    = INST_NUM_WIDTH'(`INST_JAL);
  localparam logic [INST_NUM_WIDTH-1:0] InstJalr   = INST_NUM_WIDTH'(`INST_JALR);
  localparam logic [INST_NUM_WIDTH-1:0] InstBeq    = INST_NUM_WIDTH'(`INST_BEQ);
  localparam logic [INST_NUM_WIDTH-1:0] InstSw     = INST_NUM_WIDTH'(`INST_SW);
  localparam logic [INST_NUM_WIDTH-1:0] InstEbreak = INST_NUM_WIDTH'(`INST_EBREAK);

  typedef enum logic [2:0] {
    StIdle,
    StExec0,
    StExec1,
    StMem,
    StWb,
    StHalt
  } state_e;

  state_e                      state_q, state_d;
  logic [INST_NUM_WIDTH-1:0]   cur_q, cur_d;
  logic                        taken_q, taken_d;
  logic [WaitW-1:0]            wait_q, wait_d;
  logic [CNT_WIDTH-1:0]        retired_q, retired_d;
  logic                        err_q, err_d;
  logic                        ready_int;

  logic is_jump, is_link, is_beq;

  assign is_jump = (cur_q == InstJal) || (cur_q == InstJalr);
  assign is_link = (cur_q == InstAdd) || (cur_q == InstAddi) || (cur_q == InstAuipc) || is_jump;
  assign is_beq  = (cur_q == InstBeq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      taken_q   <= 1'b0;
      wait_q    <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      taken_q   <= taken_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    taken_d    = taken_q;
    wait_d     = '0;  // clears whenever the controller is outside MEM
    retired_d  = retired_q;
    err_d      = err_q;
    ready_int  = 1'b0;
    alu_phase  = 1'b0;
    link_wen   = 1'b0;
    target_wen = 1'b0;
    mem_req    = 1'b0;
    reg_wen    = 1'b0;
    pc_wen     = 1'b0;
    pc_sel     = 1'b0;
    halt       = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready_int = 1'b1;
        if (in_valid) begin
          cur_d   = inst_num;
          state_d = StExec0;
        end
      end
      StExec0: begin
        link_wen = is_link;
        case (cur_q)
          InstAdd, InstAddi, InstAuipc: state_d = StWb;
          InstJal, InstJalr:            state_d = StExec1;
          InstSw:                       state_d = StMem;
          InstBeq: begin
            taken_d = (alu_result == '0);
            state_d = taken_d ? StExec1 : StWb;
          end
          InstEbreak: begin
            // ebreak retires without a writeback.
            state_d   = StHalt;
            retired_d = retired_q + CNT_WIDTH'(1);
          end
          default: begin
            state_d = StHalt;
            err_d   = 1'b1;
          end
        endcase
      end
      StExec1: begin
        alu_phase  = 1'b1;
        target_wen = 1'b1;
        state_d    = StWb;
      end
      StMem: begin
        mem_req = 1'b1;
        // Completion wins over a timeout landing in the same cycle.
        if (mem_ready) begin
          state_d = StWb;
        end else if (wait_q == WaitMax) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWb: begin
        pc_wen    = 1'b1;
        reg_wen   = is_link;
        pc_sel    = is_jump || (is_beq && taken_q);
        retired_d = retired_q + CNT_WIDTH'(1);
        state_d   = StIdle;
      end
      StHalt: begin
        halt = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // in_ready must read 0 for the whole time rst is held.
  assign in_ready = ready_int & ~rst;
  assign err      = err_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_exu_ctrl.sv
`timescale 1ns/1ps

`ifndef INST_NUM_WIDTH
`define INST_NUM_WIDTH 6
`endif
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef INST_ADD
`define INST_ADD 1
`endif
`ifndef INST_ADDI
`define INST_ADDI 2
`endif
`ifndef INST_AUIPC
`define INST_AUIPC 3
`endif
`ifndef INST_JAL
`define INST_JAL 4
`endif
`ifndef INST_JALR
`define INST_JALR 5
`endif
`ifndef INST_BEQ
`define INST_BEQ 6
`endif
`ifndef INST_SW
`define INST_SW 7
`endif
`ifndef INST_EBREAK
`define INST_EBREAK 8
`endif

module tb_exu_ctrl;

  localparam int IW  = `INST_NUM_WIDTH;
  localparam int XW  = `ISA_WIDTH;
  localparam int CW  = 32;
  localparam int TO0 = 255;
  localparam int TO3 = 3;

  localparam int I_ADD = `INST_ADD, I_ADDI = `INST_ADDI, I_AUIPC = `INST_AUIPC;
  localparam int I_JAL = `INST_JAL, I_JALR = `INST_JALR, I_BEQ = `INST_BEQ;
  localparam int I_SW = `INST_SW, I_EBREAK = `INST_EBREAK;

  // Observed vector: {in_ready, alu_phase, link_wen, target_wen, mem_req,
  //                   reg_wen, pc_wen, pc_sel, halt, err}
  typedef logic [9:0] vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [IW-1:0] inst_num;
  logic [XW-1:0] alu_result;
  logic          mem_ready;

  logic          rdy0, ph0, lw0, tw0, mq0, rw0, pw0, ps0, h0, e0;
  logic          rdy3, ph3, lw3, tw3, mq3, rw3, pw3, ps3, h3, e3;
  logic [CW-1:0] retired0, retired3;
  vec_t          obs0, obs3;

  assign obs0 = {rdy0, ph0, lw0, tw0, mq0, rw0, pw0, ps0, h0, e0};
  assign obs3 = {rdy3, ph3, lw3, tw3, mq3, rw3, pw3, ps3, h3, e3};

  exu_ctrl #(.MEM_TIMEOUT(TO0), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .inst_num(inst_num),
    .alu_result(alu_result), .alu_phase(ph0), .link_wen(lw0), .target_wen(tw0),
    .mem_req(mq0), .mem_ready(mem_ready), .reg_wen(rw0), .pc_wen(pw0), .pc_sel(ps0),
    .halt(h0), .err(e0), .retired(retired0)
  );

  // Short-timeout copy sharing the same stimulus, for the timeout scenarios.
  exu_ctrl #(.MEM_TIMEOUT(TO3), .CNT_WIDTH(CW)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .inst_num(inst_num),
    .alu_result(alu_result), .alu_phase(ph3), .link_wen(lw3), .target_wen(tw3),
    .mem_req(mq3), .mem_ready(mem_ready), .reg_wen(rw3), .pc_wen(pw3), .pc_sel(ps3),
    .halt(h3), .err(e3), .retired(retired3)
  );

  always #5 clk = ~clk;

  int   nvec = 0;
  int   nerr = 0;
  int   exp_ret = 0;
  vec_t exp_q[$];

  function automatic vec_t v(input bit ir, ph, lw, tw, mq, rw, pw, ps, h, e);
    return {ir, ph, lw, tw, mq, rw, pw, ps, h, e};
  endfunction

  // Expected per-cycle output trace after an accept, derived from the instruction
  // class rules; also advances the expected retired count.
  task automatic build_trace(input int inst, input logic [XW-1:0] alu, input int waits,
                             input int to);
    exp_q.delete();
    if (inst == I_ADD || inst == I_ADDI || inst == I_AUIPC) begin
      exp_q.push_back(v(0,0,1,0,0,0,0,0,0,0));
      exp_q.push_back(v(0,0,0,0,0,1,1,0,0,0));
      exp_q.push_back(v(1,0,0,0,0,0,0,0,0,0));
      exp_ret++;
    end else if (inst == I_JAL || inst == I_JALR) begin
      exp_q.push_back(v(0,0,1,0,0,0,0,0,0,0));
      exp_q.push_back(v(0,1,0,1,0,0,0,0,0,0));
      exp_q.push_back(v(0,0,0,0,0,1,1,1,0,0));
      exp_q.push_back(v(1,0,0,0,0,0,0,0,0,0));
      exp_ret++;
    end else if (inst == I_BEQ) begin
      exp_q.push_back(v(0,0,0,0,0,0,0,0,0,0));
      if (alu == 0) begin
        exp_q.push_back(v(0,1,0,1,0,0,0,0,0,0));
        exp_q.push_back(v(0,0,0,0,0,0,1,1,0,0));
      end else begin
        exp_q.push_back(v(0,0,0,0,0,0,1,0,0,0));
      end
      exp_q.push_back(v(1,0,0,0,0,0,0,0,0,0));
      exp_ret++;
    end else if (inst == I_SW) begin
      exp_q.push_back(v(0,0,0,0,0,0,0,0,0,0));
      for (int k = 0; k <= to; k++) begin
        exp_q.push_back(v(0,0,0,0,1,0,0,0,0,0));
        if (k >= waits) begin
          exp_q.push_back(v(0,0,0,0,0,0,1,0,0,0));
          exp_q.push_back(v(1,0,0,0,0,0,0,0,0,0));
          exp_ret++;
          break;
        end else if (k == to) begin
          for (int j = 0; j < 3; j++) exp_q.push_back(v(0,0,0,0,0,0,0,0,1,1));
        end
      end
    end else if (inst == I_EBREAK) begin
      exp_q.push_back(v(0,0,0,0,0,0,0,0,0,0));
      for (int j = 0; j < 3; j++) exp_q.push_back(v(0,0,0,0,0,0,0,0,1,0));
      exp_ret++;
    end else begin
      exp_q.push_back(v(0,0,0,0,0,0,0,0,0,0));
      for (int j = 0; j < 3; j++) exp_q.push_back(v(0,0,0,0,0,0,0,0,1,1));
    end
  endtask

  // Issue one instruction from IDLE and check every following cycle of its trace.
  // sel picks which instance is observed (0: default timeout, 1: timeout 3).
  task automatic run_inst(input string name, input bit sel, input int inst,
                          input logic [XW-1:0] alu, input int waits);
    vec_t obs;
    obs = sel ? obs3 : obs0;
    nvec++;
    if (obs[9] !== 1'b1) begin
      nerr++;
      $display("FAIL %s accept-ready: got in_ready=%b want 1", name, obs[9]);
    end
    build_trace(inst, alu, waits, sel ? TO3 : TO0);
    in_valid   = 1'b1;
    inst_num   = IW'(inst);
    alu_result = XW'($urandom);
    mem_ready  = 1'($urandom);
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(posedge clk);
      #1;
      obs = sel ? obs3 : obs0;
      nvec++;
      if (obs !== exp_q[c-1]) begin
        nerr++;
        $display("FAIL %s cycle %0d: got %b want %b", name, c, obs, exp_q[c-1]);
      end
      // Inputs for cycle c; in_valid is noise except in the final IDLE cycle.
      in_valid   = exp_q[c-1][9] ? 1'b0 : 1'($urandom);
      inst_num   = IW'($urandom);
      alu_result = (c == 1) ? alu : XW'($urandom);
      mem_ready  = (c >= 2) ? ((c - 2) >= waits) : 1'($urandom);
    end
    nvec++;
    if ((sel ? retired3 : retired0) !== CW'(exp_ret)) begin
      nerr++;
      $display("FAIL %s retired: got %0d want %0d", name, sel ? retired3 : retired0, exp_ret);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_ret  = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (obs0 !== '0 || retired0 !== '0) begin
        nerr++;
        $display("FAIL reset-hold dut: got %b/%0d want 0/0", obs0, retired0);
      end
      nvec++;
      if (obs3 !== '0 || retired3 !== '0) begin
        nerr++;
        $display("FAIL reset-hold dut3: got %b/%0d want 0/0", obs3, retired3);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    nvec++;
    if (obs0 !== v(1,0,0,0,0,0,0,0,0,0) || obs3 !== v(1,0,0,0,0,0,0,0,0,0)) begin
      nerr++;
      $display("FAIL reset-release: got %b/%b want in_ready only", obs0, obs3);
    end
  endtask

  task automatic test_idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      inst_num = IW'($urandom);
      @(posedge clk);
      #1;
      nvec++;
      if (obs0 !== v(1,0,0,0,0,0,0,0,0,0)) begin
        nerr++;
        $display("FAIL idle-gap: got %b want in_ready only", obs0);
      end
    end
  endtask

  task automatic test_add();
    run_inst("add", 0, I_ADD, XW'($urandom), 0);
  endtask

  task automatic test_beq();
    run_inst("beq-taken", 0, I_BEQ, '0, 0);
    run_inst("beq-not-taken", 0, I_BEQ, XW'(5), 0);
  endtask

  task automatic test_jal();
    run_inst("jal", 0, I_JAL, XW'($urandom), 0);
    run_inst("jalr", 0, I_JALR, XW'($urandom), 0);
  endtask

  task automatic test_store();
    run_inst("sw-wait4", 0, I_SW, XW'($urandom), 4);
    test_reset();
    run_inst("sw-timeout", 1, I_SW, XW'($urandom), 1000);
    test_reset();
    run_inst("sw-ready-at-timeout", 1, I_SW, XW'($urandom), TO3);
    test_reset();
  endtask

  task automatic test_halt();
    run_inst("add-before-ebreak", 0, I_ADD, XW'($urandom), 0);
    run_inst("ebreak", 0, I_EBREAK, XW'($urandom), 0);
    test_reset();
    run_inst("illegal-0", 0, 0, XW'($urandom), 0);
    test_reset();
    run_inst("illegal-rand", 0, int'($urandom_range(9, (1 << IW) - 1)), XW'($urandom), 0);
    test_reset();
  endtask

  task automatic test_reset_midflight();
    // Park in MEM waiting on a store, then reset.
    in_valid  = 1'b1;
    inst_num  = IW'(I_SW);
    mem_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (c >= 2) begin
        nvec++;
        if (mq0 !== 1'b1) begin
          nerr++;
          $display("FAIL midflight-mem_req cycle %0d: got %b want 1", c, mq0);
        end
      end
    end
    test_reset();
    run_inst("add-after-mem-reset", 0, I_ADD, XW'($urandom), 0);
    run_inst("ebreak-then-reset", 0, I_EBREAK, XW'($urandom), 0);
    test_reset();
    run_inst("add-after-halt-reset", 0, I_ADD, XW'($urandom), 0);
  endtask

  task automatic test_back_to_back();
    run_inst("b2b-addi", 0, I_ADDI, XW'($urandom), 0);
    run_inst("b2b-auipc", 0, I_AUIPC, XW'($urandom), 0);
    run_inst("b2b-add", 0, I_ADD, XW'($urandom), 0);
  endtask

  task automatic test_random();
    int legal[8] = '{I_ADD, I_ADDI, I_AUIPC, I_JAL, I_JALR, I_BEQ, I_SW, I_BEQ};
    int inst;
    logic [XW-1:0] alu;
    for (int n = 0; n < 40; n++) begin
      inst = legal[$urandom_range(0, 7)];
      alu  = $urandom_range(0, 1) ? '0 : XW'($urandom);
      run_inst("random", 0, inst, alu, int'($urandom_range(0, 6)));
      test_idle_gap(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    inst_num   = '0;
    alu_result = '0;
    mem_ready  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_idle_gap(2);
    test_beq();
    test_jal();
    test_back_to_back();
    test_store();
    test_halt();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/exu_ctrl.md
# exu_ctrl

Multi-cycle sequencer for the execute stage. It accepts one decoded instruction at a time from the decoder through a valid/ready handshake and time-multiplexes the single shared ALU over one or two phases. It also drives the store request to the LSU and pulses the register-file and PC write enables at writeback. It sits between the IDU and the `exu_alu` operand/function muxes, which use `alu_phase` as an extra select; it halts the core on `ebreak`, on an illegal `inst_num`, or on a memory timeout.

## Interface
- `INST_NUM_WIDTH`, default `` `INST_NUM_WIDTH ``: width of the decoded instruction number; encodings are the `config.v` macros.
- `ISA_WIDTH`, default `` `ISA_WIDTH ``: datapath width.
- `MEM_TIMEOUT`, default 255: maximum number of cycles spent waiting for `mem_ready`.
- `CNT_WIDTH`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: the IDU presents an instruction.
- `in_ready` out 1: the controller can accept an instruction.
- `inst_num` in `INST_NUM_WIDTH`: decoded instruction number, sampled on the handshake.
- `alu_result` in `ISA_WIDTH`: shared ALU output.
- `alu_phase` out 1: 0 selects the first ALU operation, 1 selects the second.
- `link_wen` out 1: latch `alu_result` as the link/result value.
- `target_wen` out 1: latch `alu_result` as the next-PC target.
- `mem_req` out 1: store request to the LSU.
- `mem_ready` in 1: the LSU has completed the store.
- `reg_wen` out 1: register-file write enable, one-cycle pulse.
- `pc_wen` out 1: PC write enable, one-cycle pulse.
- `pc_sel` out 1: 1 loads the PC from the latched target; 0 loads pc+4.
- `halt` out 1: sticky halt.
- `err` out 1: sticky error; valid while `halt` is 1.
- `retired` out `CNT_WIDTH`: count of retired instructions.

## Operation
- States: IDLE, EXEC0, EXEC1, MEM, WB, HALT.
- IDLE
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`: register `inst_num` into `cur`, then go to EXEC0.
- EXEC0
  - `alu_phase` = 0.
  - `link_wen` = 1 for add, addi, auipc, jal, jalr.
  - Next state by `cur`:
    - add/addi/auipc → WB.
    - jal/jalr → EXEC1.
    - sw → MEM.
    - beq: register `taken` = (`alu_result` == 0). If taken → EXEC1, else → WB.
    - ebreak → HALT, with `err` = 0; counts as retired.
    - any other value → HALT, with `err` = 1; not retired.
- EXEC1
  - `alu_phase` = 1, `target_wen` = 1, then → WB.
- MEM
  - `mem_req` = 1 for every cycle in this state.
  - A wait counter clears on entry and increments on each cycle where `mem_ready` = 0.
  - `mem_ready` = 1 → WB. This takes priority over the timeout in the same cycle.
  - Counter == `MEM_TIMEOUT` with `mem_ready` = 0 → HALT, `err` = 1.
- WB
  - `pc_wen` = 1.
  - `reg_wen` = 1 for add, addi, auipc, jal, jalr.
  - `pc_sel` = 1 for jal, jalr, and taken beq.
  - `retired` increments by 1, wrapping modulo 2^`CNT_WIDTH`; then → IDLE.
- HALT
  - `halt` = 1 and all strobes are 0. `in_ready` = 0 and `in_valid` is ignored.
  - The controller stays in HALT until `rst`.
- All strobes are Moore outputs decoded from state and `cur`. Every output not listed for a state is 0.

## Timing
- Reset
  - Asserting `rst` at any time, including mid-instruction, forces IDLE immediately.
  - It also clears `cur`, `taken`, the wait counter, `retired`, `halt` and `err`.
  - While `rst` = 1, every output is 0, including `in_ready`.
  - After release, `in_ready` = 1 in the first cycle.
- Handshake
  - Accept happens on the edge where `in_valid` & `in_ready`.
  - `in_ready` drops the following cycle and returns only in IDLE. There is at most one instruction in flight.
- Latency, counted from the accept edge to the cycle `pc_wen` is asserted:
  - add/addi/auipc/not-taken beq: 2 cycles (EXEC0, WB).
  - jal/jalr/taken beq: 3 cycles.
  - sw: 3 cycles plus wait cycles, with a maximum of `MEM_TIMEOUT`+3.
- Throughput: the next accept comes no sooner than the cycle after WB, so the minimum issue interval is 3 cycles.
- ebreak
  - `halt` rises in the cycle after EXEC0.
  - `retired` increments on that same edge.
  - `pc_wen` and `reg_wen` never assert.

## Test plan
- Reset, then `in_valid`=1 with add → EXEC0, then WB with `reg_wen`=`pc_wen`=1 and `pc_sel`=0; `in_ready` returns 3 cycles after accept; `retired`=1.
- beq with `alu_result`=0 in EXEC0 → EXEC1 with `target_wen`=1, then WB with `pc_sel`=1 and `reg_wen`=0. Repeat with `alu_result`=5 → WB directly with `pc_sel`=0.
- jal → `link_wen` in EXEC0, `target_wen` with `alu_phase`=1 in EXEC1, then WB with `reg_wen`=`pc_sel`=1.
- Store timeout:
  - sw with `mem_ready` delayed 4 cycles → `mem_req` high for 5 cycles, then WB.
  - sw with `MEM_TIMEOUT`=3 and `mem_ready` held 0 → `halt`=`err`=1, `retired` unchanged.
  - `mem_ready`=1 exactly on the timeout cycle → WB.
- ebreak → `halt`=1, `err`=0, `retired`+1; further `in_valid` is ignored. An unknown `inst_num` → `halt`=`err`=1.
- Assert `rst` during MEM and during HALT → all outputs 0, `retired`=0; normal add retires after release.
